// File: rtl/truth_table_sequencer_if.sv
// Bus bundle for truth_table_sequencer: sweep request, golden table and
// datapath return in, stimulus vector and sweep results out.
// The DUT uses the slave modport; the environment driving it uses master.
interface truth_table_sequencer_if #(
  parameter int unsigned N_IN = 3
);
  localparam int unsigned ROWS = 1 << N_IN;

  logic            start;
  logic [ROWS-1:0] expected;
  logic            s;
  logic [N_IN-1:0] vec;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   errs;
  logic            fail_vld;
  logic [N_IN-1:0] fail_row;
  logic [ROWS-1:0] capture;

  modport master (
    output start, expected, s,
    input  vec, busy, done, pass, errs, fail_vld, fail_row, capture
  );

  modport slave (
    input  start, expected, s,
    output vec, busy, done, pass, errs, fail_vld, fail_row, capture
  );
endinterface

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: walks every row of an N_IN-input truth table,
// drives the row onto vec, samples the datapath result s one cycle later
// and compares it with a golden table latched at start.
// Optional feature: define TT_CAPTURE_EN to record the sampled s of every
// row in capture; without it capture is tied to zero and no storage exists.
module truth_table_sequencer #(
  parameter int unsigned N_IN = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  truth_table_sequencer_if.slave  bus
);
  localparam int unsigned ROWS = 1 << N_IN;
  localparam int unsigned EW   = N_IN + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic [N_IN-1:0] r_row;
  logic [N_IN-1:0] r_vec;
  logic [ROWS-1:0] r_expected;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic [EW-1:0]   r_errs;
  logic            r_fail_vld;
  logic [N_IN-1:0] r_fail_row;

  logic            w_accept;
  logic            w_mismatch;
  logic            w_last_row;

  // Start is only honoured from IDLE; busy and DONE periods ignore it.
  assign w_accept   = (r_state == S_IDLE) && bus.start;
  assign w_mismatch = (bus.s != r_expected[r_row]);
  assign w_last_row = (r_row == N_IN'(ROWS - 1));

  // Sweep sequencer: state, row walk, error count and first-failure capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_row      <= '0;
      r_vec      <= '0;
      r_expected <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_errs     <= '0;
      r_fail_vld <= 1'b0;
      r_fail_row <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state    <= S_DRIVE;
            r_row      <= '0;
            r_vec      <= '0;
            r_expected <= bus.expected;
            r_busy     <= 1'b1;
            r_pass     <= 1'b0;
            r_errs     <= '0;
            r_fail_vld <= 1'b0;
            r_fail_row <= '0;
          end
        end
        S_DRIVE: begin
          // vec already carries the row; give the datapath a cycle to settle.
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (w_mismatch) begin
            r_errs <= r_errs + EW'(1);
            if (!r_fail_vld) begin
              r_fail_vld <= 1'b1;
              r_fail_row <= r_row;
            end
          end
          if (w_last_row) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_vec   <= '0;
          end else begin
            r_state <= S_DRIVE;
            r_row   <= r_row + N_IN'(1);
            r_vec   <= r_row + N_IN'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_pass  <= (r_errs == '0);
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.vec      = r_vec;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.pass     = r_pass;
  assign bus.errs     = r_errs;
  assign bus.fail_vld = r_fail_vld;
  assign bus.fail_row = r_fail_row;

`ifdef TT_CAPTURE_EN
  logic [ROWS-1:0] r_capture;

  // Per-row record of the sampled datapath result, cleared on each accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_capture <= '0;
    end else if (w_accept) begin
      r_capture <= '0;
    end else if (r_state == S_CHECK) begin
      r_capture[r_row] <= bus.s;
    end
  end

  assign bus.capture = r_capture;
`else
  assign bus.capture = '0;
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Self-checking bench for truth_table_sequencer (N_IN = 3).
// Stimulus pushes the hand-computed sweep result into a scoreboard; a
// monitor pops and compares it whenever done is seen.
module tb_truth_table_sequencer;
  localparam int unsigned N_IN   = 3;
  localparam int unsigned ROWS   = 1 << N_IN;
  localparam int          PERIOD = 10;

`ifdef TT_CAPTURE_EN
  localparam logic [ROWS-1:0] CAP_OK = 8'h8A;
`else
  localparam logic [ROWS-1:0] CAP_OK = 8'h00;
`endif

  typedef struct {
    logic [N_IN:0]   errs;
    logic            pass;
    logic            fail_vld;
    logic [N_IN-1:0] fail_row;
    logic [ROWS-1:0] capture;
    longint          t_start;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   mode = 0;  // 0: s = ~(x & ~y) & z, 1: s tied low

  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_count = 0;
  exp_t sb[$];

  always #(PERIOD/2) clk = ~clk;

  truth_table_sequencer_if #(.N_IN(N_IN)) bus();

  truth_table_sequencer #(.N_IN(N_IN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.s = (mode == 0) ? (~(bus.vec[2] & ~bus.vec[1]) & bus.vec[0]) : 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vec"},      32'(bus.vec),      32'd0);
    check({tag, "_busy"},     32'(bus.busy),     32'd0);
    check({tag, "_done"},     32'(bus.done),     32'd0);
    check({tag, "_pass"},     32'(bus.pass),     32'd0);
    check({tag, "_errs"},     32'(bus.errs),     32'd0);
    check({tag, "_fail_vld"}, 32'(bus.fail_vld), 32'd0);
    check({tag, "_fail_row"}, 32'(bus.fail_row), 32'd0);
    check({tag, "_capture"},  32'(bus.capture),  32'd0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding sweep.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done) begin
      done_count++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: done high with no sweep outstanding at %0t", $time);
      end else begin
        e = sb.pop_front();
        check("errs",     32'(bus.errs),     32'(e.errs));
        check("pass",     32'(bus.pass),     32'(e.pass));
        check("fail_vld", 32'(bus.fail_vld), 32'(e.fail_vld));
        check("fail_row", 32'(bus.fail_row), 32'(e.fail_row));
        check("capture",  32'(bus.capture),  32'(e.capture));
        check("latency",  32'(($time - PERIOD/2 - e.t_start) / PERIOD), 32'd17);
      end
    end
  end

  task automatic sweep(input logic [ROWS-1:0] golden, input int m,
                       input logic [N_IN:0] errs, input logic pass,
                       input logic fv, input logic [N_IN-1:0] frow,
                       input logic [ROWS-1:0] cap);
    exp_t e;
    @(negedge clk);
    mode         = m;
    bus.expected = golden;
    bus.start    = 1'b1;
    @(posedge clk);
    e.errs = errs; e.pass = pass; e.fail_vld = fv; e.fail_row = frow;
    e.capture = cap; e.t_start = longint'($time);
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check({tag, "_drain_timeout"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int d0;
    exp_t e;
    bus.start    = 1'b0;
    bus.expected = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Correct datapath against its own table.
    sweep(8'h8A, 0, 4'd0, 1'b1, 1'b0, 3'd0, CAP_OK);
    drain("t1");

    // Golden table wrong in row 0 only.
    sweep(8'h8B, 0, 4'd1, 1'b0, 1'b1, 3'd0, CAP_OK);
    drain("t2");
    repeat (5) @(negedge clk);
    check("hold_errs",     32'(bus.errs),     32'd1);
    check("hold_pass",     32'(bus.pass),     32'd0);
    check("hold_fail_vld", 32'(bus.fail_vld), 32'd1);
    check("hold_fail_row", 32'(bus.fail_row), 32'd0);

    // s stuck low: rows 1, 3, 7 mismatch.
    sweep(8'h8A, 1, 4'd3, 1'b0, 1'b1, 3'd1, 8'h00);
    drain("t3");

    // Reset in the middle of a sweep that has already seen mismatches.
    d0 = done_count;
    @(negedge clk);
    mode = 0; bus.expected = 8'h00; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check("midrst_no_done", 32'(done_count - d0), 32'd0);
    sweep(8'h8A, 0, 4'd0, 1'b1, 1'b0, 3'd0, CAP_OK);
    drain("t4");

    // Start held high and golden table toggled during the sweep.
    d0 = done_count;
    @(negedge clk);
    mode = 0; bus.expected = 8'h8A; bus.start = 1'b1;
    @(posedge clk);
    e.errs = 4'd0; e.pass = 1'b1; e.fail_vld = 1'b0; e.fail_row = 3'd0;
    e.capture = CAP_OK; e.t_start = longint'($time);
    sb.push_back(e);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.expected = (i % 2 == 0) ? 8'h75 : 8'h8A;
    end
    @(negedge clk);
    bus.start = 1'b0;
    drain("t5");
    repeat (5) @(negedge clk);
    check("held_start_one_done", 32'(done_count - d0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/truth_table_sequencer.md
TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 SHALL provide parameter N_IN, default 3, meaning number of Boolean inputs driven (legal 1..4); ROWS = 2^N_IN.
REQ-002 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst, input, 1: one clock; reset is asynchronous and active-high.
REQ-004 SHALL provide port start, input, 1, requests one full truth-table sweep.
REQ-005 SHALL provide port expected, input, ROWS, golden output; bit i is the expected result for row i.
REQ-006 SHALL provide port s, input, 1, result returned by the evaluated expression datapath.
REQ-007 SHALL provide port vec, output, N_IN, inputs applied to the datapath (MSB = x, LSB = z for N_IN = 3).
REQ-008 SHALL provide port busy, output, 1, high while a sweep is in progress.
REQ-009 SHALL provide port done, output, 1, one-cycle pulse at sweep end.
REQ-010 SHALL provide port pass, output, 1, sweep result: no mismatches.
REQ-011 SHALL provide port errs, output, N_IN+1, mismatch count of the last sweep.
REQ-012 SHALL provide port fail_vld, output, 1, and fail_row, output, N_IN: first mismatching row.
REQ-013 SHALL provide port capture, output, ROWS, sampled s per row (see Configuration).

Function
REQ-014 SHALL implement states IDLE, DRIVE, CHECK, DONE.
REQ-015 IDLE: start=1 -> DRIVE. Row counter cleared. expected latched. errs, fail_vld, pass and capture cleared.
REQ-016 DRIVE: vec = row; next state CHECK unconditionally.
REQ-017 CHECK: s sampled with vec still = row; s != latched expected[row] increments errs.
REQ-018 CHECK: the first mismatch of a sweep sets fail_vld=1 and fail_row=row; later mismatches leave fail_row unchanged.
REQ-019 CHECK: row = ROWS-1 -> DONE, else row+1 -> DRIVE; no wrap past ROWS-1.
REQ-020 DONE: done=1 for exactly one cycle, pass = (errs == 0); next state IDLE.
REQ-021 pass, errs, fail_vld, fail_row and capture SHALL hold until the next accepted start.
REQ-022 Latency: start sampled at edge k -> done high in the cycle after edge k+2*ROWS+1 (17 cycles later for N_IN=3).
REQ-023 busy SHALL be 1 in DRIVE and CHECK and 0 in IDLE and DONE.
REQ-024 start while busy or in DONE SHALL be ignored; expected changes after latching SHALL have no effect.
REQ-025 s SHALL be treated as combinational from vec; no other timing dependency.
REQ-026 vec SHALL equal 0 when in IDLE and DONE.

Reset
REQ-027 rst=1 SHALL immediately force IDLE. Cleared to 0: row, vec, busy, done, pass, errs, fail_vld, fail_row and capture.
REQ-028 Reset mid-sweep SHALL abort with no done pulse; the next start after deassertion SHALL run a full, correct sweep.

Configuration
REQ-029 Macro TT_CAPTURE_EN defined: each CHECK SHALL write s into capture[row].
REQ-030 Macro TT_CAPTURE_EN undefined: capture SHALL be constant 0, with no capture storage synthesised; all other behaviour identical.

Verification
REQ-031 Datapath s = ~(x & ~y) & z, expected=8'h8A, start pulse -> errs=0, pass=1, fail_vld=0, done exactly 17 cycles after start edge.
REQ-032 Same datapath, expected=8'h8B -> errs=1, pass=0, fail_vld=1, fail_row=0.
REQ-033 s tied 0, expected=8'h8A -> errs=3, fail_row=1, pass=0.
REQ-034 Start, rst pulsed during cycle 6, then start with correct datapath -> all outputs 0 after reset, no done pulse, then second sweep as in REQ-031.
REQ-035 Start reasserted every cycle while busy and expected toggled mid-sweep -> single sweep, result per originally latched value, one done pulse.
REQ-036 With TT_CAPTURE_EN and correct datapath -> capture=8'h8A; without the macro -> capture=8'h00.
